piso_serializer: RTL and testbench
==================================

# piso_serializer

Parametrised parallel-in/serial-out shifter for the serial transmit path. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per `bit_en` strobe, LSB- or MSB-first. An optional parity bit can be appended. The line idles at a fixed level between words. It replaces the fixed 8-bit, LSB-first shifter, adding handshaking, frame completion reporting and gapless back-to-back transmission.

## Interface
- `WIDTH`, 8: data word width, ≥2.
- `MSB_FIRST`, 0: 0 = bit 0 first; 1 = bit WIDTH-1 first.
- `PARITY`, 0: 0 = none; 1 = even; 2 = odd. Parity is appended after the last data bit.
- `IDLE_BIT`, 1: line level when idle, and fill value for vacated shift positions.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_in`  in  WIDTH  parallel word, sampled on accept.
- `load_valid`  in  1  producer has a word.
- `load_ready`  out  1  block accepts a word this cycle.
- `bit_en`  in  1  one-cycle strobe (baud tick); advances the serial stream by one bit.
- `data_out`  out  1  serial line; registered.
- `busy`  out  1  a frame is in progress.
- `done`  out  1  one-cycle pulse when the final frame bit's period ends.

## Operation
- Frame length `FLEN = WIDTH + (PARITY != 0)`.
- Counter width is `$clog2(FLEN+1)`.
- States:
  - IDLE: `data_out = IDLE_BIT`, `busy = 0`.
  - SHIFT: `data_out` = current frame bit, `busy = 1`.
- Accept condition: `load_valid && load_ready`.
  - Loads the shift register with `data_in`, plus the parity bit if enabled.
  - Sets `bits_left = FLEN` and enters SHIFT.
- Parity:
  - Even: `^data_in`.
  - Odd: `~^data_in`.
  - Computed at accept time from the sampled word.
- In SHIFT, each `bit_en`:
  - Shifts one position toward the output end and fills with `IDLE_BIT`.
  - Decrements `bits_left`.
- `bit_en` is ignored in IDLE. `load_valid` without `load_ready` has no effect.
- Last bit: `bit_en` with `bits_left == 1`.
  - Asserts `done` the next cycle.
  - Returns to IDLE unless a new word is accepted in the same cycle.
- `load_ready` is combinational:
  - `(state == IDLE) || (bits_left == 1 && bit_en)`.
  - Forced to 0 while `reset` is high.
- Back-to-back: an accept coinciding with the last bit reloads directly into SHIFT. The first bit of the next word follows the parity/last bit with no idle gap.
- `data_in` changes are ignored outside the accept cycle.

## Timing
- Reset (synchronous, mid-frame included):
  - State IDLE, shift register all `IDLE_BIT`, `bits_left = 0`.
  - `data_out = IDLE_BIT`, `busy = 0`, `done = 0` from the cycle after `reset` is sampled high.
  - An in-flight frame is abandoned without a `done` pulse.
- Accept at edge N: first frame bit on `data_out` and `busy = 1` from cycle N+1. The first bit is held until the first `bit_en` after acceptance.
- A `bit_en` sampled at edge M changes `data_out` at M+1.
- Frame duration is exactly FLEN `bit_en` strobes after accept.
- `done` is high for exactly one cycle, coincident with `data_out` returning to `IDLE_BIT`, or with the next word's first bit on a back-to-back load.
- `bit_en` may be asserted every cycle (full-rate) or sparsely; correctness is independent of spacing.

## Structure
- Shared package `piso_pkg`:
  - State enum (`PISO_IDLE`, `PISO_SHIFT`).
  - Parity mode constants (`PAR_NONE = 0`, `PAR_EVEN = 1`, `PAR_ODD = 2`).
  - Helper function `frame_len(width, parity)`.
- Single module, no sub-modules. Parity is a one-line reduction inside the load path.
- Shift register width is FLEN. Bit ordering is resolved at load, so shifting is always toward index 0.

## Test plan
- WIDTH=8, LSB-first, no parity: accept `0x0F`, then `bit_en` every cycle.
  - `data_out` = 1,1,1,1,0,0,0,0, then idle 1.
  - `done` pulses once, 8 strobes after accept.
- MSB_FIRST=1: accept `0x0F`.
  - `data_out` = 0,0,0,0,1,1,1,1, then 1.
- PARITY=1 with `0x07`: 9th bit is 1. PARITY=2 with `0x07`: 9th bit is 0. `done` follows the 9th bit.
- `load_valid` held high with words `0x01`, `0x80`, `bit_en` every 3rd cycle.
  - Second accept coincides with the last `bit_en` of the first word.
  - No idle bit between words.
  - `done` pulses twice.
  - `load_ready` is low between accepts.
- Assert `reset` after 3 of 8 bits.
  - Next cycle: `data_out = 1`, `busy = 0`, `load_ready = 1`, no `done`.
  - A fresh `0xAA` accept then transmits correctly.
- `bit_en` pulses while idle and `data_in` toggling outside accept: `data_out` stays 1, no state change.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types, parity mode encodings and frame-length helper for the serial
// transmit shifter.
package piso_pkg;

  typedef enum logic [0:0] {
    PISO_IDLE  = 1'b0,
    PISO_SHIFT = 1'b1
  } piso_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // Number of line bits per frame: data bits plus an optional parity bit.
  function automatic int unsigned frame_len(input int unsigned width,
                                            input int unsigned parity);
    return width + ((parity != PAR_NONE) ? 1 : 0);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with valid/ready load, selectable bit order,
// optional parity, done pulse and gapless back-to-back frames.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 0,
  parameter int unsigned PARITY    = PAR_NONE,
  parameter logic        IDLE_BIT  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             bit_en,
  output logic             data_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned FLEN = frame_len(WIDTH, PARITY);
  localparam int unsigned CW   = $clog2(FLEN + 1);

  piso_state_e     state_q, state_d;
  logic [FLEN-1:0] sreg_q, sreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            dout_q, dout_d;
  logic            done_q, done_d;

  logic            last_bit;
  logic            accept;
  logic            par_bit;
  logic [FLEN-1:0] load_word;

  // Handshake and last-bit detection; ready opens on the final strobe so the
  // next word is loaded without an idle gap.
  always_comb begin
    last_bit   = (state_q == PISO_SHIFT) && (cnt_q == CW'(1)) && bit_en;
    load_ready = !reset && ((state_q == PISO_IDLE) || last_bit);
    accept     = load_valid && load_ready;
  end

  // Frame image: bit order resolved here so the register always shifts toward
  // index 0; parity sits above the last data bit.
  always_comb begin
    par_bit   = (PARITY == PAR_ODD) ? ~^data_in : ^data_in;
    load_word = {FLEN{IDLE_BIT}};
    for (int unsigned i = 0; i < WIDTH; i++) begin
      load_word[i] = (MSB_FIRST != 0) ? data_in[WIDTH-1-i] : data_in[i];
    end
    if (PARITY != PAR_NONE) begin
      load_word[FLEN-1] = par_bit;
    end
  end

  // Next-state: load wins over shifting, so a load on the last strobe
  // replaces the exhausted frame directly.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    done_d  = last_bit;
    if (accept) begin
      state_d = PISO_SHIFT;
      sreg_d  = load_word;
      cnt_d   = CW'(FLEN);
    end else if ((state_q == PISO_SHIFT) && bit_en) begin
      sreg_d = {IDLE_BIT, sreg_q[FLEN-1:1]};
      cnt_d  = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = PISO_IDLE;
      end
    end
    dout_d = (state_d == PISO_SHIFT) ? sreg_d[0] : IDLE_BIT;
  end

  // State registers with synchronous reset; reset abandons a frame silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PISO_IDLE;
      sreg_q  <= {FLEN{IDLE_BIT}};
      cnt_q   <= '0;
      dout_q  <= IDLE_BIT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end

  assign data_out = dout_q;
  assign busy     = (state_q == PISO_SHIFT);
  assign done     = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: four serializer configurations (LSB/none, MSB/none,
// LSB/even, LSB/odd). Stimulus pushes expected line bits; a negedge monitor
// pops one entry per consumed bit and checks done after each final bit.
module tb_piso_serializer;
  import piso_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst = '0;
  logic [3:0] lv  = '0;
  logic [3:0] be  = '0;
  logic [7:0] din [4];
  wire  [3:0] lr, dout, busy, done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int unsigned inst;
    logic        b;
    logic        last;
  } exp_t;
  exp_t sb[$];
  logic [3:0] pend = '0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned MSB = (g == 1) ? 1 : 0;
    localparam int unsigned PAR = (g == 2) ? PAR_EVEN : ((g == 3) ? PAR_ODD : PAR_NONE);
    piso_serializer #(
      .WIDTH    (8),
      .MSB_FIRST(MSB),
      .PARITY   (PAR),
      .IDLE_BIT (1'b1)
    ) u_dut (
      .clk       (clk),
      .reset     (rst[g]),
      .data_in   (din[g]),
      .load_valid(lv[g]),
      .load_ready(lr[g]),
      .bit_en    (be[g]),
      .data_out  (dout[g]),
      .busy      (busy[g]),
      .done      (done[g])
    );
  end

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected line bits for one word on instance inst.
  function automatic void push_word(input int unsigned inst, input logic [7:0] w);
    logic msb, par, pbit;
    exp_t e;
    msb  = (inst == 1);
    par  = (inst == 2) || (inst == 3);
    pbit = (inst == 3) ? ~^w : ^w;
    for (int k = 0; k < 8; k++) begin
      e.inst = inst;
      e.b    = msb ? w[7-k] : w[k];
      e.last = !par && (k == 7);
      sb.push_back(e);
    end
    if (par) begin
      e.inst = inst;
      e.b    = pbit;
      e.last = 1'b1;
      sb.push_back(e);
    end
  endfunction

  // Monitor: a bit is consumed when bit_en meets busy; done must follow
  // exactly one cycle after the final bit is consumed and never otherwise.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (pend[i]) begin
        chk($sformatf("done_pulse[%0d]", i), done[i], 1'b1);
        pend[i] = 1'b0;
      end else if (done[i] === 1'b1) begin
        total++;
        bad++;
        $display("FAIL done_spurious[%0d]: got 1 want 0 (t=%0t)", i, $time);
      end
      if (be[i] === 1'b1 && busy[i] === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL bit_unexpected[%0d]: got %b want none", i, dout[i]);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.inst != i) begin
            total++;
            bad++;
            $display("FAIL bit_inst: got inst %0d want inst %0d", i, e.inst);
          end else begin
            chk($sformatf("serial_bit[%0d]", i), dout[i], e.b);
          end
          if (e.last) pend[i] = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int unsigned i, input logic [7:0] w);
    din[i] = w;
    lv[i]  = 1'b1;
    be[i]  = 1'b0;
    #1;
    chk($sformatf("ready_idle[%0d]", i), lr[i], 1'b1);
    push_word(i, w);
    step();
    lv[i]  = 1'b0;
    din[i] = 8'($urandom);
  endtask

  task automatic strobes(input int unsigned i, input int n, input int gap);
    for (int s = 0; s < n; s++) begin
      be[i] = 1'b1;
      step();
      be[i]  = 1'b0;
      din[i] = 8'($urandom);
      repeat (gap) step();
    end
  endtask

  task automatic check_idle(input int unsigned i, input string tag);
    chk({tag, "_dout"}, dout[i], 1'b1);
    chk({tag, "_busy"}, busy[i], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) din[i] = 8'h00;

    // Reset all instances.
    rst = 4'hF;
    step();
    step();
    for (int i = 0; i < 4; i++) chk($sformatf("ready_in_reset[%0d]", i), lr[i], 1'b0);
    rst = 4'h0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check_idle(i, $sformatf("reset_state[%0d]", i));
      chk($sformatf("reset_done[%0d]", i), done[i], 1'b0);
    end

    // LSB first, no parity, 0x0F at full rate.
    accept(0, 8'h0F);
    chk("lsb_busy", busy[0], 1'b1);
    strobes(0, 8, 0);
    step();
    check_idle(0, "lsb_after");

    // MSB first 0x0F: first bit 0 held until first strobe.
    accept(1, 8'h0F);
    step();
    step();
    chk("msb_hold_dout", dout[1], 1'b0);
    chk("msb_hold_busy", busy[1], 1'b1);
    strobes(1, 8, 0);
    step();
    check_idle(1, "msb_after");

    // Even and odd parity on 0x07 (parity bits 1 and 0).
    accept(2, 8'h07);
    strobes(2, 9, 1);
    step();
    check_idle(2, "even_after");
    accept(3, 8'h07);
    strobes(3, 9, 2);
    step();
    check_idle(3, "odd_after");

    // Back-to-back 0x01 then 0x80, load_valid held, bit_en every 3rd cycle.
    din[0] = 8'h01;
    lv[0]  = 1'b1;
    be[0]  = 1'b0;
    #1;
    chk("b2b_ready_first", lr[0], 1'b1);
    push_word(0, 8'h01);
    step();
    din[0] = 8'h80;
    for (int s = 1; s <= 8; s++) begin
      repeat (2) begin
        be[0] = 1'b0;
        #1;
        chk("b2b_ready_low", lr[0], 1'b0);
        step();
      end
      be[0] = 1'b1;
      #1;
      if (s == 8) begin
        chk("b2b_ready_last", lr[0], 1'b1);
        push_word(0, 8'h80);
      end else begin
        chk("b2b_ready_low", lr[0], 1'b0);
      end
      step();
    end
    lv[0] = 1'b0;
    be[0] = 1'b0;
    chk("b2b_busy", busy[0], 1'b1);
    chk("b2b_first_bit", dout[0], 1'b0);
    strobes(0, 8, 2);
    step();
    check_idle(0, "b2b_after");

    // Reset after 3 of 8 bits, then a fresh 0xAA.
    accept(0, 8'h00);
    strobes(0, 3, 0);
    sb.delete();
    rst[0] = 1'b1;
    #1;
    chk("midreset_ready", lr[0], 1'b0);
    step();
    rst[0] = 1'b0;
    #1;
    check_idle(0, "midreset");
    chk("midreset_ready_after", lr[0], 1'b1);
    chk("midreset_done", done[0], 1'b0);
    accept(0, 8'hAA);
    strobes(0, 8, 0);
    step();
    check_idle(0, "post_reset_after");

    // bit_en and data_in activity while idle must not disturb the line.
    for (int c = 0; c < 10; c++) begin
      be[0]  = c[0];
      din[0] = 8'($urandom);
      step();
      check_idle(0, "idle_noise");
      chk("idle_noise_ready", lr[0], 1'b1);
    end
    be[0] = 1'b0;
    accept(0, 8'h3C);
    strobes(0, 8, 1);
    step();
    check_idle(0, "final_after");

    step();
    step();
    total++;
    if (sb.size() != 0 || pend != 4'h0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left pend=%b want 0 left", sb.size(), pend);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
